// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage RAW scoreboard: tracks rd of EX/MEM/WB instrs, stalls decode combinationally, registers EX bubble/forward selects.
// Optional FORWARDING_EN: forward from EX/MEM and MEM/WB, stalling only on load-use; otherwise stall until the producer retires.
module pipeline_hazard_ctrl #(
   parameter int WB_BYPASS   = 1,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   dec_valid_i,
   input  logic [4:0]             dec_rs1_i,
   input  logic [4:0]             dec_rs2_i,
   input  logic                   dec_rs1_used_i,
   input  logic                   dec_rs2_used_i,
   input  logic [4:0]             dec_rd_i,
   input  logic                   dec_reg_write_i,
   input  logic                   dec_is_load_i,
   input  logic                   flush_i,
   output logic                   stall_o,
   output logic                   issue_o,
   output logic                   bubble_o,
   output logic [1:0]             fwd_a_sel_o,
   output logic [1:0]             fwd_b_sel_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } trk_t;

   trk_t                   s1_q, s2_q, s3_q, s1_d;
   logic                   bubble_q, bubble_d;
   logic [1:0]             fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   function automatic logic match(input trk_t e, input logic [4:0] rs, input logic used);
      return e.vld & e.wr & (e.rd == rs) & (rs != 5'd0) & used;
   endfunction

   logic hit1_a, hit1_b, hit2_a, hit2_b, hit3_a, hit3_b;
   logic wb_haz, hazard;

   assign hit1_a = match(s1_q, dec_rs1_i, dec_rs1_used_i);
   assign hit1_b = match(s1_q, dec_rs2_i, dec_rs2_used_i);
   assign hit2_a = match(s2_q, dec_rs1_i, dec_rs1_used_i);
   assign hit2_b = match(s2_q, dec_rs2_i, dec_rs2_used_i);
   assign hit3_a = match(s3_q, dec_rs1_i, dec_rs1_used_i);
   assign hit3_b = match(s3_q, dec_rs2_i, dec_rs2_used_i);

   // A non-bypassing regfile returns the stale value while WB is writing it.
   assign wb_haz = (WB_BYPASS == 0) & (hit3_a | hit3_b);

`ifdef FORWARDING_EN
   assign hazard = ((hit1_a | hit1_b) & s1_q.ld) | wb_haz;
`else
   assign hazard = hit1_a | hit1_b | hit2_a | hit2_b | wb_haz;
`endif

   assign stall_o = dec_valid_i & ~flush_i & hazard;
   assign issue_o = dec_valid_i & ~flush_i & ~stall_o;

   always_comb begin
      s1_d     = '0;
      bubble_d = ~issue_o;
      fwd_a_d  = 2'b00;
      fwd_b_d  = 2'b00;
      if (issue_o) begin
         s1_d.vld = 1'b1;
         s1_d.rd  = dec_rd_i;
         s1_d.wr  = dec_reg_write_i;
         s1_d.ld  = dec_is_load_i;
`ifdef FORWARDING_EN
         // Youngest producer wins: EX/MEM result is newer than MEM/WB.
         if (hit1_a)      fwd_a_d = 2'b01;
         else if (hit2_a) fwd_a_d = 2'b10;
         if (hit1_b)      fwd_b_d = 2'b01;
         else if (hit2_b) fwd_b_d = 2'b10;
`endif
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_o && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q        <= '0;
         s2_q        <= '0;
         s3_q        <= '0;
         bubble_q    <= 1'b1;
         fwd_a_q     <= 2'b00;
         fwd_b_q     <= 2'b00;
         stall_cnt_q <= '0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s1_q;
         s3_q        <= s2_q;
         bubble_q    <= bubble_d;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bubble_o    = bubble_q;
   assign fwd_a_sel_o = fwd_a_q;
   assign fwd_b_sel_o = fwd_b_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule
